// File: rtl/ssd_pkg.sv
// Shared types for the seven-segment display scheduler: FSM states, source
// encodings and the 6-bit display operand type.
package ssd_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_CHG = 2'd1,
        SHOW_ERR = 2'd2
    } state_e;

    localparam logic [1:0] SRC_COST = 2'b00;
    localparam logic [1:0] SRC_CHG  = 2'b01;
    localparam logic [1:0] SRC_ERR  = 2'b10;

    typedef logic [5:0] disp_val_t;
endpackage

// File: rtl/ssd_display_scheduler_if.sv
// Request/acknowledge and display-operand bundle between the vending FSM,
// the scheduler and the display controller.
interface ssd_display_scheduler_if;
    import ssd_pkg::*;

    disp_val_t  cost_x, cost_y;
    logic       chg_req, err_req;
    disp_val_t  chg_x, chg_y, err_x, err_y;
    logic       chg_ack, err_ack;
    disp_val_t  disp_x, disp_y;
    logic       blank;
    logic [1:0] src;
    logic       busy;

    modport master (
        output cost_x, cost_y, chg_req, chg_x, chg_y, err_req, err_x, err_y,
        input  chg_ack, err_ack, disp_x, disp_y, blank, src, busy
    );

    modport slave (
        input  cost_x, cost_y, chg_req, chg_x, chg_y, err_req, err_x, err_y,
        output chg_ack, err_ack, disp_x, disp_y, blank, src, busy
    );
endinterface

// File: rtl/ssd_hold_timer.sv
// Loadable down-counter; expire is high during the cycle whose closing edge
// brings the count to zero.
module ssd_hold_timer
    import ssd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = value;
        else if (count_q != '0)
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign expire = (count_q == W'(1));
endmodule

// File: rtl/ssd_display_scheduler.sv
// Arbitrates the display operands between the idle cost readout, a timed
// change message and a timed blinking error message (error has priority).
module ssd_display_scheduler
    import ssd_pkg::*;
#(
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    ssd_display_scheduler_if.slave  bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_VAL  = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0] BLINK_VAL = BW'(BLINK_CYCLES);

    state_e     state_q, state_d;
    logic       chg_pend_q, chg_pend_d, err_pend_q, err_pend_d;
    disp_val_t  chg_x_q, chg_x_d, chg_y_q, chg_y_d;
    disp_val_t  err_x_q, err_x_d, err_y_q, err_y_d;
    disp_val_t  disp_x_q, disp_x_d, disp_y_q, disp_y_d;
    logic       blank_q, blank_d, busy_q, busy_d;
    logic [1:0] src_q, src_d;
    logic       chg_ack_q, chg_ack_d, err_ack_q, err_ack_d;

    logic hold_load, blink_load, hold_exp, blink_exp;
    logic go_err, go_chg, go_idle;

    ssd_hold_timer #(.W(HW)) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load),
        .value  (HOLD_VAL),
        .expire (hold_exp)
    );

    ssd_hold_timer #(.W(BW)) u_blink (
        .clk    (clk),
        .reset  (reset),
        .load   (blink_load),
        .value  (BLINK_VAL),
        .expire (blink_exp)
    );

    // A pending request always wins over hold expiry, so reloads restart the hold.
    always_comb begin
        go_err  = 1'b0;
        go_chg  = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            IDLE: begin
                go_err = err_pend_q;
                go_chg = !err_pend_q && chg_pend_q;
            end
            SHOW_ERR: begin
                go_err  = err_pend_q;
                go_chg  = !err_pend_q && hold_exp && chg_pend_q;
                go_idle = !err_pend_q && hold_exp && !chg_pend_q;
            end
            SHOW_CHG: begin
                go_err  = err_pend_q;
                go_chg  = !err_pend_q && chg_pend_q;
                go_idle = !err_pend_q && !chg_pend_q && hold_exp;
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        disp_x_d   = disp_x_q;
        disp_y_d   = disp_y_q;
        blank_d    = blank_q;
        chg_pend_d = chg_pend_q;
        chg_x_d    = chg_x_q;
        chg_y_d    = chg_y_q;
        err_pend_d = err_pend_q;
        err_x_d    = err_x_q;
        err_y_d    = err_y_q;
        hold_load  = 1'b0;
        blink_load = 1'b0;

        if (go_err) begin
            // A preempted change goes back into its slot unless a newer one is waiting.
            if (state_q == SHOW_CHG && !chg_pend_q) begin
                chg_pend_d = 1'b1;
                chg_x_d    = disp_x_q;
                chg_y_d    = disp_y_q;
            end
            state_d    = SHOW_ERR;
            disp_x_d   = err_x_q;
            disp_y_d   = err_y_q;
            blank_d    = 1'b0;
            err_pend_d = 1'b0;
            hold_load  = 1'b1;
            blink_load = 1'b1;
        end else if (go_chg) begin
            state_d    = SHOW_CHG;
            disp_x_d   = chg_x_q;
            disp_y_d   = chg_y_q;
            blank_d    = 1'b0;
            chg_pend_d = 1'b0;
            hold_load  = 1'b1;
        end else if (go_idle || state_q == IDLE) begin
            state_d  = IDLE;
            disp_x_d = bus.cost_x;
            disp_y_d = bus.cost_y;
            blank_d  = 1'b0;
        end else if (state_q == SHOW_ERR && blink_exp) begin
            blank_d    = !blank_q;
            blink_load = 1'b1;
        end

        // Fresh captures land last: the latest request owns its slot.
        if (bus.chg_req) begin
            chg_pend_d = 1'b1;
            chg_x_d    = bus.chg_x;
            chg_y_d    = bus.chg_y;
        end
        if (bus.err_req) begin
            err_pend_d = 1'b1;
            err_x_d    = bus.err_x;
            err_y_d    = bus.err_y;
        end

        chg_ack_d = bus.chg_req;
        err_ack_d = bus.err_req;

        case (state_d)
            SHOW_CHG: src_d = SRC_CHG;
            SHOW_ERR: src_d = SRC_ERR;
            default:  src_d = SRC_COST;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            chg_pend_q <= 1'b0;
            chg_x_q    <= '0;
            chg_y_q    <= '0;
            err_pend_q <= 1'b0;
            err_x_q    <= '0;
            err_y_q    <= '0;
            disp_x_q   <= '0;
            disp_y_q   <= '0;
            blank_q    <= 1'b0;
            src_q      <= SRC_COST;
            busy_q     <= 1'b0;
            chg_ack_q  <= 1'b0;
            err_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            chg_pend_q <= chg_pend_d;
            chg_x_q    <= chg_x_d;
            chg_y_q    <= chg_y_d;
            err_pend_q <= err_pend_d;
            err_x_q    <= err_x_d;
            err_y_q    <= err_y_d;
            disp_x_q   <= disp_x_d;
            disp_y_q   <= disp_y_d;
            blank_q    <= blank_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            chg_ack_q  <= chg_ack_d;
            err_ack_q  <= err_ack_d;
        end
    end

    assign bus.disp_x  = disp_x_q;
    assign bus.disp_y  = disp_y_q;
    assign bus.blank   = blank_q;
    assign bus.src     = src_q;
    assign bus.busy    = busy_q;
    assign bus.chg_ack = chg_ack_q;
    assign bus.err_ack = err_ack_q;
endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Directed bench: a message-timeline model (age counted from appearance)
// is compared every cycle, plus hand-computed spot checks.
module tb_ssd_display_scheduler;
    import ssd_pkg::*;

    localparam int HOLD  = 8;
    localparam int BLINK = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    ssd_display_scheduler_if bus ();

    ssd_display_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: current message kind (0 cost, 1 change, 2 error), its age in
    // cycles since it appeared, and one pending slot per source.
    int         m_kind = 0;
    int         m_age  = 0;
    logic [5:0] m_x = 0, m_y = 0, m_cx = 0, m_cy = 0, m_ex = 0, m_ey = 0;
    logic       m_chg_p = 0, m_err_p = 0, m_ack_c = 0, m_ack_e = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_kind = 0; m_age = 0; m_x = 0; m_y = 0;
            m_chg_p = 0; m_err_p = 0; m_ack_c = 0; m_ack_e = 0;
        end else begin
            if (m_err_p) begin
                if (m_kind == 1 && !m_chg_p) begin
                    m_chg_p = 1; m_cx = m_x; m_cy = m_y;
                end
                m_kind = 2; m_x = m_ex; m_y = m_ey; m_err_p = 0; m_age = 0;
            end else if (m_chg_p && (m_kind != 2 || m_age == HOLD - 1)) begin
                m_kind = 1; m_x = m_cx; m_y = m_cy; m_chg_p = 0; m_age = 0;
            end else if (m_kind != 0 && m_age == HOLD - 1) begin
                m_kind = 0;
            end else if (m_kind != 0) begin
                m_age++;
            end
            if (m_kind == 0) begin
                m_x = bus.cost_x; m_y = bus.cost_y;
            end
            m_ack_c = bus.chg_req;
            m_ack_e = bus.err_req;
            if (bus.chg_req) begin m_chg_p = 1; m_cx = bus.chg_x; m_cy = bus.chg_y; end
            if (bus.err_req) begin m_err_p = 1; m_ex = bus.err_x; m_ey = bus.err_y; end
        end
    end

    always @(negedge clk) begin
        chk("disp_x",  32'(bus.disp_x),  32'(m_x));
        chk("disp_y",  32'(bus.disp_y),  32'(m_y));
        chk("blank",   32'(bus.blank),   32'((m_kind == 2) && ((m_age / BLINK) % 2 == 1)));
        chk("src",     32'(bus.src),     32'(m_kind));
        chk("busy",    32'(bus.busy),    32'(m_kind != 0));
        chk("chg_ack", 32'(bus.chg_ack), 32'(m_ack_c));
        chk("err_ack", 32'(bus.err_ack), 32'(m_ack_e));
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one request cycle; returns on the negedge right after capture.
    task automatic req(input logic c, input logic [5:0] cx, input logic [5:0] cy,
                       input logic e, input logic [5:0] ex, input logic [5:0] ey);
        @(negedge clk);
        bus.chg_req = c; bus.chg_x = cx; bus.chg_y = cy;
        bus.err_req = e; bus.err_x = ex; bus.err_y = ey;
        @(negedge clk);
        bus.chg_req = 1'b0;
        bus.err_req = 1'b0;
    endtask

    logic [7:0] bl;

    initial begin
        bus.cost_x = 6'd12; bus.cost_y = 6'd3;
        bus.chg_req = 0; bus.chg_x = 0; bus.chg_y = 0;
        bus.err_req = 0; bus.err_x = 0; bus.err_y = 0;
        bl = '0;

        wait_n(2);
        chk("rst_disp_x", 32'(bus.disp_x), 0);
        chk("rst_src",    32'(bus.src),    0);
        reset = 1'b0;
        wait_n(1);
        chk("idle_cost_x", 32'(bus.disp_x), 12);
        chk("idle_cost_y", 32'(bus.disp_y), 3);

        // single change message
        req(1, 6'd7, 6'd0, 0, 6'd0, 6'd0);
        chk("chg_ack_pulse", 32'(bus.chg_ack), 1);
        chk("src_before_show", 32'(bus.src), 0);
        wait_n(1);
        chk("chg_shown_x", 32'(bus.disp_x), 7);
        chk("chg_src", 32'(bus.src), 1);
        chk("chg_busy", 32'(bus.busy), 1);
        wait_n(7);
        chk("chg_last_cycle", 32'(bus.disp_x), 7);
        wait_n(1);
        chk("chg_done_x", 32'(bus.disp_x), 12);
        chk("chg_done_busy", 32'(bus.busy), 0);

        // error preempts a change, change re-shown afterwards
        req(1, 6'd5, 6'd1, 0, 6'd0, 6'd0);
        wait_n(1);
        chk("pre_chg_x", 32'(bus.disp_x), 5);
        wait_n(2);
        req(0, 6'd0, 6'd0, 1, 6'd63, 6'd63);
        chk("err_ack_pulse", 32'(bus.err_ack), 1);
        wait_n(1);
        chk("err_x", 32'(bus.disp_x), 63);
        chk("err_src", 32'(bus.src), 2);
        bl[0] = bus.blank;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            bl[i] = bus.blank;
        end
        chk("blink_pattern", 32'(bl), 32'(8'b1100_1100));
        wait_n(1);
        chk("reshow_chg_x", 32'(bus.disp_x), 5);
        chk("reshow_src", 32'(bus.src), 1);
        wait_n(7);
        chk("reshow_full_hold", 32'(bus.disp_x), 5);
        wait_n(1);
        chk("reshow_done_src", 32'(bus.src), 0);

        // simultaneous requests
        req(1, 6'd20, 6'd21, 1, 6'd10, 6'd11);
        chk("both_chg_ack", 32'(bus.chg_ack), 1);
        chk("both_err_ack", 32'(bus.err_ack), 1);
        wait_n(1);
        chk("both_err_first", 32'(bus.disp_x), 10);
        wait_n(8);
        chk("both_chg_next", 32'(bus.disp_x), 20);
        chk("both_chg_src", 32'(bus.src), 1);
        wait_n(8);
        chk("both_idle_src", 32'(bus.src), 0);
        chk("both_idle_x", 32'(bus.disp_x), 12);

        // second change restarts hold
        req(1, 6'd4, 6'd4, 0, 6'd0, 6'd0);
        wait_n(1);
        chk("first_chg_x", 32'(bus.disp_x), 4);
        wait_n(3);
        req(1, 6'd9, 6'd2, 0, 6'd0, 6'd0);
        chk("still_first_x", 32'(bus.disp_x), 4);
        wait_n(1);
        chk("second_chg_x", 32'(bus.disp_x), 9);
        chk("second_chg_y", 32'(bus.disp_y), 2);
        wait_n(7);
        chk("second_full_hold", 32'(bus.disp_x), 9);
        wait_n(1);
        chk("second_done_x", 32'(bus.disp_x), 12);

        // cost follows one cycle later in idle, frozen while busy
        @(negedge clk);
        bus.cost_x = 6'd20; bus.cost_y = 6'd0;
        chk("cost_not_yet", 32'(bus.disp_x), 12);
        wait_n(1);
        chk("cost_follow_x", 32'(bus.disp_x), 20);
        chk("cost_follow_y", 32'(bus.disp_y), 0);
        req(1, 6'd1, 6'd1, 0, 6'd0, 6'd0);
        wait_n(1);
        bus.cost_x = 6'd30; bus.cost_y = 6'd30;
        chk("busy_ignores_cost", 32'(bus.disp_x), 1);
        wait_n(7);
        chk("busy_ignores_cost_end", 32'(bus.disp_x), 1);
        wait_n(1);
        chk("cost_after_busy", 32'(bus.disp_x), 30);

        // reset in the middle of an error with a change pending
        bus.cost_x = 6'd12; bus.cost_y = 6'd3;
        req(1, 6'd2, 6'd2, 1, 6'd33, 6'd44);
        wait_n(1);
        chk("err2_x", 32'(bus.disp_x), 33);
        wait_n(2);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_x", 32'(bus.disp_x), 0);
        chk("async_rst_src", 32'(bus.src), 0);
        chk("async_rst_blank", 32'(bus.blank), 0);
        chk("async_rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_n(1);
        chk("post_rst_x", 32'(bus.disp_x), 12);
        chk("post_rst_y", 32'(bus.disp_y), 3);
        wait_n(10);
        chk("post_rst_no_pending", 32'(bus.src), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
